// File: rtl/spi_sram_pkg.sv
// Shared constants, FSM state type and helpers for the SPI serial-SRAM controller.
package spi_sram_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam int         FRAME_BITS = 32;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;

    // Write wins when both qualifiers are set; a bare request is treated as a read.
    function automatic logic dir_is_write(input logic rd, input logic wr);
        case ({wr, rd})
            2'b10, 2'b11: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter producing the SCLK level plus rise/fall strobes.
module spi_sclk_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    logic [7:0] cnt;
    logic       wrap;

    assign wrap      = en && !clear && (cnt == DIV_M1);
    assign rise_tick = wrap && !sclk;
    assign fall_tick = wrap && sclk;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt  <= '0;
                sclk <= ~sclk;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/spi_sram_ctrl.sv
// CPU-side single-byte access to a 23LC512-class SPI SRAM: one mode-0 frame per request.
module spi_sram_ctrl #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic        cpu_req,
    output logic        cpu_ready,
    output logic [7:0]  cpu_rdata,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    import spi_sram_pkg::*;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    state_t                state, state_nx;
    logic [FRAME_BITS-1:0] shreg;
    logic [4:0]            bit_cnt;
    logic [7:0]            hold_cnt;
    logic [7:0]            rx_byte;
    logic                  is_wr;
    logic                  wr_dir;
    logic                  sh_en;
    logic                  rise_tick;
    logic                  fall_tick;

    assign wr_dir = dir_is_write(cpu_read, cpu_write);
    assign sh_en  = (state == SHIFT);

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk       (clk),
        .reset     (reset),
        .en        (sh_en),
        .clear     (!sh_en),
        .sclk      (spi_sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cpu_req) state_nx = SHIFT;
            SHIFT:   if (fall_tick && bit_cnt == 5'd31) state_nx = HOLD;
            HOLD:    if (hold_cnt == DIV_M1) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            hold_cnt  <= '0;
            rx_byte   <= '0;
            is_wr     <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (cpu_req) begin
                        is_wr   <= wr_dir;
                        bit_cnt <= '0;
                        shreg   <= {wr_dir ? CMD_WRITE : CMD_READ, cpu_addr,
                                    wr_dir ? cpu_wdata : 8'h00};
                    end
                end
                SHIFT: begin
                    // Only the final 8 samples survive, which is exactly the data byte.
                    if (rise_tick) rx_byte <= {rx_byte[6:0], spi_miso};
                    if (fall_tick) begin
                        shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 8'd1;
                    if (state_nx == DONE && !is_wr) cpu_rdata <= rx_byte;
                end
                default: hold_cnt <= '0;
            endcase
        end
    end

    assign spi_cs_n  = !(state == SHIFT || state == HOLD);
    assign spi_mosi  = (state == SHIFT) && shreg[FRAME_BITS-1];
    assign cpu_ready = (state == DONE);

endmodule
